hub75_bcm_driver: RTL and testbench

Parametrised HUB75 LED matrix panel driver; successor to the fixed 64-column, 16-row-address, RGB332 driver. It scans a dual-half panel one row address at a time and shifts full-colour pixel data one bit plane per pass. Brightness per plane uses binary code modulation (BCM), so each colour channel has BPC bits of intensity. It sits between the frame buffer read port and the panel connector, and issues row/col/plane read addresses to the frame buffer.

---
 rtl/hub75_bcm_driver.sv | 208 ++++++++++++++++++++
 tb/tb_hub75_bcm_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_driver.sv
// HUB75 LED matrix driver with binary code modulation.
// Scans one row address at a time and shifts one bit plane per pass
// (SHIFT -> LATCH -> DISPLAY). Each plane is displayed for BASE_TIME << plane cycles.
// Optional build macro HUB75_BRIGHTNESS_EN adds a global brightness input.
// This input shortens the unblanked part of each DISPLAY window.
// The window length itself does not change.
//
// state   | meaning
// IDLE    | one cycle after reset before the first pass
// SHIFT   | COLS+1 two-cycle slots: address column, sample, clock data out
// LATCH   | two cycles: latch strobe + row address update, then strobe low
// DISPLAY | BASE_TIME << plane cycles of panel on-time for the current plane
module hub75_bcm_driver #(
    parameter int COLS          = 64,
    parameter int ROW_ADDR_BITS = 4,
    parameter int BPC           = 3,
    parameter int BASE_TIME     = 8,
    localparam int CW           = $clog2(COLS),
    localparam int PW           = (BPC > 1) ? $clog2(BPC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3*BPC-1:0]         rgb_top,
    input  logic [3*BPC-1:0]         rgb_bot,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]               brightness,
`endif
    output logic [ROW_ADDR_BITS-1:0] row,
    output logic [CW-1:0]            col,
    output logic [PW-1:0]            plane,
    output logic                     frame_start,
    output logic                     panel_r0,
    output logic                     panel_g0,
    output logic                     panel_b0,
    output logic                     panel_r1,
    output logic                     panel_g1,
    output logic                     panel_b1,
    output logic [ROW_ADDR_BITS-1:0] panel_addr,
    output logic                     panel_sclk,
    output logic                     panel_latch,
    output logic                     panel_blank
);

    localparam int SW  = $clog2(COLS + 1);
    localparam int DW  = $clog2((BASE_TIME << (BPC - 1)) + 1);
    localparam int PRW = DW + 8;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t                   state, nxt_state;
    logic [SW-1:0]            slot, nxt_slot;
    logic                     phase, nxt_phase;
    logic [DW-1:0]            dcnt, nxt_dcnt;
    logic [DW-1:0]            on_cnt, nxt_on;
    logic [DW-1:0]            disp_len, on_len;
    logic [ROW_ADDR_BITS-1:0] nxt_row, nxt_addr;
    logic [PW-1:0]            nxt_plane;
    logic [CW-1:0]            nxt_col;
    logic                     nxt_fs, nxt_sclk, nxt_latch, nxt_blank;
    logic [5:0]               data_q, nxt_data;
    logic [BPC-1:0]           r_t, g_t, b_t, r_b, g_b, b_b;

    assign r_t = rgb_top[3*BPC-1 -: BPC];
    assign g_t = rgb_top[2*BPC-1 -: BPC];
    assign b_t = rgb_top[BPC-1:0];
    assign r_b = rgb_bot[3*BPC-1 -: BPC];
    assign g_b = rgb_bot[2*BPC-1 -: BPC];
    assign b_b = rgb_bot[BPC-1:0];

    assign disp_len = DW'(BASE_TIME) << plane;

    assign {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1} = data_q;

`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0]     bright_q;
    logic [PRW-1:0] on_prod;

    // Brightness is captured on the first latch cycle and held for that pass
    always_ff @(posedge clk) begin
        if (rst)
            bright_q <= '0;
        else if (state == LATCH && !phase)
            bright_q <= brightness;
    end

    // Unblanked part of DISPLAY scaled by brightness/256
    always_comb begin
        on_prod = PRW'(disp_len) * PRW'(bright_q);
        on_len  = DW'(on_prod >> 8);
    end
`else
    assign on_len = disp_len;
`endif

    // Next state, counters and next registered outputs
    always_comb begin
        nxt_state = state;
        nxt_slot  = slot;
        nxt_phase = phase;
        nxt_dcnt  = dcnt;
        nxt_on    = on_cnt;
        nxt_row   = row;
        nxt_plane = plane;
        nxt_data  = data_q;
        nxt_addr  = panel_addr;

        case (state)
            IDLE: begin
                nxt_state = SHIFT;
                nxt_slot  = '0;
                nxt_phase = 1'b0;
            end
            SHIFT: begin
                if (phase) begin
                    // Slot COLS only flushes the last column; nothing new is sampled
                    nxt_data = (slot < SW'(COLS)) ?
                        {r_t[plane], g_t[plane], b_t[plane], r_b[plane], g_b[plane], b_b[plane]} : '0;
                    nxt_phase = 1'b0;
                    if (slot == SW'(COLS)) begin
                        nxt_state = LATCH;
                        nxt_slot  = '0;
                    end else begin
                        nxt_slot = slot + SW'(1);
                    end
                end else begin
                    nxt_phase = 1'b1;
                end
            end
            LATCH: begin
                nxt_data = '0;
                if (phase) begin
                    nxt_phase = 1'b0;
                    nxt_state = DISPLAY;
                    nxt_dcnt  = disp_len - DW'(1);
                    nxt_on    = on_len;
                end else begin
                    nxt_phase = 1'b1;
                end
            end
            DISPLAY: begin
                nxt_data = '0;
                if (on_cnt != '0)
                    nxt_on = on_cnt - DW'(1);
                if (dcnt == '0) begin
                    nxt_state = SHIFT;
                    nxt_slot  = '0;
                    nxt_phase = 1'b0;
                    if (plane == PW'(BPC - 1)) begin
                        nxt_plane = '0;
                        nxt_row   = row + ROW_ADDR_BITS'(1);
                    end else begin
                        nxt_plane = plane + PW'(1);
                    end
                end else begin
                    nxt_dcnt = dcnt - DW'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase

        nxt_col   = '0;
        if (nxt_state == SHIFT)
            nxt_col = (nxt_slot < SW'(COLS)) ? CW'(nxt_slot) : CW'(COLS - 1);
        nxt_sclk  = (nxt_state == SHIFT) && nxt_phase && (nxt_slot != '0);
        nxt_fs    = (nxt_state == SHIFT) && !nxt_phase && (nxt_slot == '0) &&
                    (nxt_row == '0) && (nxt_plane == '0);
        nxt_latch = (nxt_state == LATCH) && !nxt_phase;
        if (nxt_latch)
            nxt_addr = row;
        nxt_blank = !((nxt_state == DISPLAY) && (nxt_on != '0));
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= '0;
            phase       <= 1'b0;
            dcnt        <= '0;
            on_cnt      <= '0;
            row         <= '0;
            plane       <= '0;
            col         <= '0;
            frame_start <= 1'b0;
            data_q      <= '0;
            panel_addr  <= '0;
            panel_sclk  <= 1'b0;
            panel_latch <= 1'b0;
            panel_blank <= 1'b1;
        end else begin
            state       <= nxt_state;
            slot        <= nxt_slot;
            phase       <= nxt_phase;
            dcnt        <= nxt_dcnt;
            on_cnt      <= nxt_on;
            row         <= nxt_row;
            plane       <= nxt_plane;
            col         <= nxt_col;
            frame_start <= nxt_fs;
            data_q      <= nxt_data;
            panel_addr  <= nxt_addr;
            panel_sclk  <= nxt_sclk;
            panel_latch <= nxt_latch;
            panel_blank <= nxt_blank;
        end
    end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver: COLS=4, ROW_ADDR_BITS=1, BPC=2.
// Honours HUB75_BRIGHTNESS_EN (BASE_TIME=8, brightness 128 then 0).
module tb_hub75_bcm_driver;

    localparam int COLS = 4;
    localparam int RAB  = 1;
    localparam int BPC  = 2;
`ifdef HUB75_BRIGHTNESS_EN
    localparam int BT         = 8;
    localparam int EXP_PERIOD = 96;
    localparam int EXP_W0     = 4;
    localparam int EXP_W1     = 8;
`else
    localparam int BT         = 2;
    localparam int EXP_PERIOD = 60;
    localparam int EXP_W0     = 2;
    localparam int EXP_W1     = 4;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [5:0]     rgb_top = '0;
    logic [5:0]     rgb_bot = '0;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0]     brightness = 8'd128;
`endif
    logic [RAB-1:0] row;
    logic [1:0]     col;
    logic [0:0]     plane;
    logic           frame_start;
    logic           panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1;
    logic [RAB-1:0] panel_addr;
    logic           panel_sclk, panel_latch, panel_blank;

    hub75_bcm_driver #(
        .COLS(COLS), .ROW_ADDR_BITS(RAB), .BPC(BPC), .BASE_TIME(BT)
    ) dut (
        .clk(clk), .rst(rst), .rgb_top(rgb_top), .rgb_bot(rgb_bot),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .row(row), .col(col), .plane(plane), .frame_start(frame_start),
        .panel_r0(panel_r0), .panel_g0(panel_g0), .panel_b0(panel_b0),
        .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
        .panel_addr(panel_addr), .panel_sclk(panel_sclk),
        .panel_latch(panel_latch), .panel_blank(panel_blank)
    );

    always #5 clk = ~clk;

    // Frame buffer model, one cycle read latency.
    // top: r = col, g = 0, b = 3.
    // bot: r = 3, g = col, b = 0.
    always @(posedge clk) begin
        rgb_top <= {col, 2'b00, 2'b11};
        rgb_bot <= {2'b11, col, 2'b00};
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic [31:0] outvec;
    assign outvec = 32'({row, col, plane, frame_start, panel_r0, panel_g0, panel_b0,
                         panel_r1, panel_g1, panel_b1, panel_addr, panel_sclk,
                         panel_latch, panel_blank});

    // Event monitor
    logic cap = 1'b0;
    int   cyc = 0, edge_cnt = 0, run = 0, b0_ones = 0, g0_ones = 0;
    logic prev_sclk = 1'b0, prev_blank = 1'b1;
    int   fs_t[$], r0q[$], g1q[$], latq[$], edq[$], runq[$], addrq[$];

    always @(negedge clk) begin
        if (cap) begin
            cyc++;
            if (frame_start) fs_t.push_back(cyc);
            if (panel_sclk && !prev_sclk) begin
                r0q.push_back(int'(panel_r0));
                g1q.push_back(int'(panel_g1));
                b0_ones += int'(panel_b0);
                g0_ones += int'(panel_g0);
                edge_cnt++;
            end
            if (panel_latch) begin
                latq.push_back(int'(panel_blank));
                edq.push_back(edge_cnt);
                edge_cnt = 0;
            end
            if (!panel_blank) begin
                if (prev_blank) addrq.push_back(int'(panel_addr));
                run++;
            end else if (!prev_blank) begin
                runq.push_back(run);
                run = 0;
            end
            prev_sclk  = panel_sclk;
            prev_blank = panel_blank;
        end
    end

    initial begin
        int   nib_r, nib_g, lat_ones, exp_nib, lows;
        logic found, seen;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outvec, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        cap = 1'b1;
        @(negedge clk);
        chk("fs_idle_cycle", 32'(frame_start), 32'd0);
        @(negedge clk);
        chk("fs_first_shift", 32'(frame_start), 32'd1);

        for (int i = 0; i < 400 && fs_t.size() < 3; i++) @(posedge clk);
        cap = 1'b0;
        chk("frames_seen", 32'(fs_t.size()), 32'd3);
        if (fs_t.size() >= 3) begin
            chk("frame_period_0", 32'(fs_t[1] - fs_t[0]), 32'(EXP_PERIOD));
            chk("frame_period_1", 32'(fs_t[2] - fs_t[1]), 32'(EXP_PERIOD));
        end

        chk("sclk_edges_total", 32'(r0q.size()), 32'd32);
        if (r0q.size() == 32) begin
            for (int p = 0; p < 8; p++) begin
                nib_r = 0;
                nib_g = 0;
                for (int k = 0; k < 4; k++) begin
                    nib_r = (nib_r << 1) | r0q[4*p+k];
                    nib_g = (nib_g << 1) | g1q[4*p+k];
                end
                exp_nib = (p % 2 == 0) ? 5 : 3;
                chk($sformatf("r0_pass%0d", p), 32'(nib_r), 32'(exp_nib));
                chk($sformatf("g1_pass%0d", p), 32'(nib_g), 32'(exp_nib));
            end
        end
        chk("b0_ones", 32'(b0_ones), 32'd32);
        chk("g0_ones", 32'(g0_ones), 32'd0);

        chk("latch_pulses", 32'(latq.size()), 32'd8);
        lat_ones = 0;
        foreach (latq[i]) lat_ones += latq[i];
        chk("latch_while_blank", 32'(lat_ones), 32'(latq.size()));
        chk("edge_groups", 32'(edq.size()), 32'd8);
        foreach (edq[i]) chk($sformatf("edges_pass%0d", i), 32'(edq[i]), 32'd4);

        chk("blank_windows", 32'(runq.size()), 32'd8);
        foreach (runq[i])
            chk($sformatf("blank_low_pass%0d", i), 32'(runq[i]), 32'((i % 2 == 0) ? EXP_W0 : EXP_W1));
        chk("addr_windows", 32'(addrq.size()), 32'd8);
        foreach (addrq[i])
            chk($sformatf("panel_addr_pass%0d", i), 32'(addrq[i]), 32'((i / 2) % 2));

        // Reset in the middle of row 1, plane 1 DISPLAY
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (row == 1'b1 && plane == 1'b1 && !panel_blank) found = 1'b1;
        end
        chk("found_row1_plane1_display", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", outvec, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("restart_fs_idle", 32'(frame_start), 32'd0);
        @(negedge clk);
        chk("restart_fs", 32'(frame_start), 32'd1);
        chk("restart_row_plane", 32'({row, plane}), 32'd0);

`ifdef HUB75_BRIGHTNESS_EN
        brightness = 8'd0;
        lows = 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
            else if (!panel_blank) lows++;
        end
        chk("bright0_frame_end", 32'(seen), 32'd1);
        chk("bright0_unblanked", 32'(lows), 32'd0);
`else
        lows = 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
            else if (!panel_blank) lows++;
        end
        chk("restart_frame_end", 32'(seen), 32'd1);
        chk("restart_unblanked_cycles", 32'(lows), 32'(2 * (EXP_W0 + EXP_W1)));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
